// File: rtl/hyper_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// hyper_xfer_sequencer
//
// Purpose:
//   Schedules HyperBus transfers from NB_REQ requesters onto the single uDMA
//   HyperBus channel. A round-robin arbiter picks one requester, the block
//   programs the channel with a fixed 4-write cfg burst (L2 address, size,
//   external address, command) and then waits for the end-of-transfer event
//   that matches the issued direction. Completion (done) or failure (err) is
//   reported back to the requester that owns the transfer.
//
// Ports:
//   sys_clk_i, rstn_i        clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  per-requester descriptor handshake (ready is a
//                            one-hot pulse in the acceptance cycle)
//   req_rd_i                 per-requester direction (1 = read into L2)
//   req_l2_addr_i            packed L2 addresses, L2_AW bits each
//   req_ext_addr_i           packed external addresses, 32 bits each
//   req_size_i               packed byte counts, SIZE_W bits each
//   done_o, err_o            one-cycle completion / error pulses per requester
//   timeout_i                watchdog limit in cycles, 0 disables it
//   cfg_*                    uDMA cfg write port (write only)
//   evt_rx_eot_i             read end-of-transfer pulse
//   evt_tx_eot_i             write end-of-transfer pulse
//   busy_o, owner_o          a transfer is owned / index of its owner
// -----------------------------------------------------------------------------
module hyper_xfer_sequencer #(
    parameter int unsigned NB_REQ    = 2,
    parameter int unsigned L2_AW     = 19,
    parameter int unsigned SIZE_W    = 20,
    parameter logic [5:0]  OFF_L2    = 6'h00,
    parameter logic [5:0]  OFF_SIZE  = 6'h04,
    parameter logic [5:0]  OFF_EXT   = 6'h08,
    parameter logic [5:0]  OFF_CMD   = 6'h0C,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                       sys_clk_i,
    input  logic                       rstn_i,
    input  logic [NB_REQ-1:0]          req_valid_i,
    output logic [NB_REQ-1:0]          req_ready_o,
    input  logic [NB_REQ-1:0]          req_rd_i,
    input  logic [NB_REQ*L2_AW-1:0]    req_l2_addr_i,
    input  logic [NB_REQ*32-1:0]       req_ext_addr_i,
    input  logic [NB_REQ*SIZE_W-1:0]   req_size_i,
    output logic [NB_REQ-1:0]          done_o,
    output logic [NB_REQ-1:0]          err_o,
    input  logic [TIMEOUT_W-1:0]       timeout_i,
    output logic                       cfg_valid_o,
    output logic                       cfg_rwn_o,
    output logic [5:0]                 cfg_addr_o,
    output logic [31:0]                cfg_data_o,
    input  logic                       cfg_ready_i,
    input  logic                       evt_rx_eot_i,
    input  logic                       evt_tx_eot_i,
    output logic                       busy_o,
    output logic [$clog2(NB_REQ)-1:0]  owner_o
);

    localparam int unsigned      IDX_W = $clog2(NB_REQ);
    localparam logic [NB_REQ-1:0] ONE  = NB_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CFG      = 2'd1,
        S_WAIT_EOT = 2'd2,
        S_FAIL     = 2'd3
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;

    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_owner;
    logic                  r_rd;
    logic [L2_AW-1:0]      r_l2;
    logic [31:0]           r_ext;
    logic [SIZE_W-1:0]     r_size;
    logic [1:0]            r_idx;
    logic [TIMEOUT_W-1:0]  r_wdog;
    logic [NB_REQ-1:0]     r_done;

    logic                  w_any;
    logic [IDX_W-1:0]      w_sel;
    logic [IDX_W-1:0]      w_ptr_nxt;
    logic                  w_rd;
    logic [L2_AW-1:0]      w_l2;
    logic [31:0]           w_ext;
    logic [SIZE_W-1:0]     w_size;
    logic                  w_match;
    logic [TIMEOUT_W-1:0]  w_wdog_inc;
    logic                  w_timeout;

    // -------------------------------------------------------------------------
    // Round-robin arbiter: first valid requester at or after r_ptr, wrapping.
    // -------------------------------------------------------------------------
    always_comb begin : arb
        int unsigned      v_idx;
        logic [IDX_W-1:0] v_cand;
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves a value held and no latch is inferred.
        v_idx  = 0;
        v_cand = '0;
        w_any  = 1'b0;
        w_sel  = '0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            v_idx = 32'(r_ptr) + i;
            if (v_idx >= NB_REQ) begin
                v_idx = v_idx - NB_REQ;
            end
            v_cand = IDX_W'(v_idx);
            if (!w_any && req_valid_i[v_cand]) begin
                w_any = 1'b1;
                w_sel = v_cand;
            end
        end
    end

    assign w_ptr_nxt = (w_sel == IDX_W'(NB_REQ - 1)) ? '0 : w_sel + 1'b1;

    // Descriptor of the selected requester, captured on acceptance.
    assign w_rd   = req_rd_i[w_sel];
    assign w_l2   = req_l2_addr_i[w_sel*L2_AW +: L2_AW];
    assign w_ext  = req_ext_addr_i[w_sel*32 +: 32];
    assign w_size = req_size_i[w_sel*SIZE_W +: SIZE_W];

    // Only the event matching the issued direction can complete a transfer.
    assign w_match    = r_rd ? evt_rx_eot_i : evt_tx_eot_i;
    // The watchdog fires on the cycle its count reaches the limit, so a limit
    // of N allows exactly N cycles in WAIT_EOT.
    assign w_wdog_inc = r_wdog + 1'b1;
    assign w_timeout  = (timeout_i != '0) && (w_wdog_inc == timeout_i);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = (w_size == '0) ? S_FAIL : S_CFG;
                end
            end
            S_CFG: begin
                if (cfg_ready_i && (r_idx == 2'd3)) begin
                    w_state_nxt = S_WAIT_EOT;
                end
            end
            S_WAIT_EOT: begin
                // A completing event beats a simultaneous timeout.
                if (w_match) begin
                    w_state_nxt = S_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = S_FAIL;
                end
            end
            S_FAIL: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers: pointer, owned descriptor, write index, watchdog.
    // -------------------------------------------------------------------------
    // NOTE: every register here is a small control/data flop, so all of them
    // take the asynchronous reset; the block holds no memory array.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_rd    <= 1'b0;
            r_l2    <= '0;
            r_ext   <= '0;
            r_size  <= '0;
            r_idx   <= '0;
            r_wdog  <= '0;
            r_done  <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ptr   <= w_ptr_nxt;
                        r_owner <= w_sel;
                        r_rd    <= w_rd;
                        r_l2    <= w_l2;
                        r_ext   <= w_ext;
                        r_size  <= w_size;
                        r_idx   <= '0;
                    end
                end
                S_CFG: begin
                    // Held at zero so WAIT_EOT starts counting from a clean value.
                    r_wdog <= '0;
                    if (cfg_ready_i) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_WAIT_EOT: begin
                    r_wdog <= w_wdog_inc;
                    if (w_match) begin
                        r_done <= ONE << r_owner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output logic
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready_o = '0;
        err_o       = '0;
        cfg_valid_o = 1'b0;
        cfg_addr_o  = '0;
        cfg_data_o  = '0;
        busy_o      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    req_ready_o = ONE << w_sel;
                end
            end
            S_CFG: begin
                // Address and data depend only on registered state, so they stay
                // stable while the cfg port back-pressures.
                cfg_valid_o = 1'b1;
                case (r_idx)
                    2'd0: begin
                        cfg_addr_o = OFF_L2;
                        cfg_data_o = 32'(r_l2);
                    end
                    2'd1: begin
                        cfg_addr_o = OFF_SIZE;
                        cfg_data_o = 32'(r_size);
                    end
                    2'd2: begin
                        cfg_addr_o = OFF_EXT;
                        cfg_data_o = r_ext;
                    end
                    default: begin
                        cfg_addr_o = OFF_CMD;
                        cfg_data_o = {30'b0, r_rd, 1'b1};
                    end
                endcase
            end
            S_FAIL: begin
                err_o = ONE << r_owner;
            end
            default: begin
            end
        endcase
    end

    assign cfg_rwn_o = 1'b0;
    assign done_o    = r_done;
    assign owner_o   = r_owner;

endmodule

// File: tb/tb_hyper_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hyper_xfer_sequencer
//
// Purpose:
//   Self-checking bench for hyper_xfer_sequencer with two requesters. Expected
//   cfg writes are pushed to a scoreboard queue when a descriptor is granted
//   and popped as the cfg port hands them over. Grants are predicted by a
//   small round-robin pointer model kept in the bench.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_hyper_xfer_sequencer;

    localparam int NB     = 2;
    localparam int L2_AW  = 19;
    localparam int SIZE_W = 20;
    localparam int TW     = 16;
    localparam int OW     = $clog2(NB);

    localparam logic [5:0] OFF_L2   = 6'h00;
    localparam logic [5:0] OFF_SIZE = 6'h04;
    localparam logic [5:0] OFF_EXT  = 6'h08;
    localparam logic [5:0] OFF_CMD  = 6'h0C;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } cfg_wr_t;

    logic                   sys_clk_i = 1'b0;
    logic                   rstn_i;
    logic [NB-1:0]          req_valid_i;
    logic [NB-1:0]          req_ready_o;
    logic [NB-1:0]          req_rd_i;
    logic [NB*L2_AW-1:0]    req_l2_addr_i;
    logic [NB*32-1:0]       req_ext_addr_i;
    logic [NB*SIZE_W-1:0]   req_size_i;
    logic [NB-1:0]          done_o;
    logic [NB-1:0]          err_o;
    logic [TW-1:0]          timeout_i;
    logic                   cfg_valid_o;
    logic                   cfg_rwn_o;
    logic [5:0]             cfg_addr_o;
    logic [31:0]            cfg_data_o;
    logic                   cfg_ready_i;
    logic                   evt_rx_eot_i;
    logic                   evt_tx_eot_i;
    logic                   busy_o;
    logic [OW-1:0]          owner_o;

    // Per-requester descriptors driven by the tests.
    logic                   d_rd   [NB];
    logic [L2_AW-1:0]       d_l2   [NB];
    logic [31:0]            d_ext  [NB];
    logic [SIZE_W-1:0]      d_size [NB];

    for (genvar g = 0; g < NB; g++) begin : g_pack
        assign req_rd_i[g]                        = d_rd[g];
        assign req_l2_addr_i[g*L2_AW +: L2_AW]    = d_l2[g];
        assign req_ext_addr_i[g*32 +: 32]         = d_ext[g];
        assign req_size_i[g*SIZE_W +: SIZE_W]     = d_size[g];
    end

    int      errors = 0;
    int      checks = 0;
    cfg_wr_t q_cfg[$];
    int      m_ptr  = 0;

    hyper_xfer_sequencer #(
        .NB_REQ    (NB),
        .L2_AW     (L2_AW),
        .SIZE_W    (SIZE_W),
        .OFF_L2    (OFF_L2),
        .OFF_SIZE  (OFF_SIZE),
        .OFF_EXT   (OFF_EXT),
        .OFF_CMD   (OFF_CMD),
        .TIMEOUT_W (TW)
    ) dut (
        .sys_clk_i      (sys_clk_i),
        .rstn_i         (rstn_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_rd_i       (req_rd_i),
        .req_l2_addr_i  (req_l2_addr_i),
        .req_ext_addr_i (req_ext_addr_i),
        .req_size_i     (req_size_i),
        .done_o         (done_o),
        .err_o          (err_o),
        .timeout_i      (timeout_i),
        .cfg_valid_o    (cfg_valid_o),
        .cfg_rwn_o      (cfg_rwn_o),
        .cfg_addr_o     (cfg_addr_o),
        .cfg_data_o     (cfg_data_o),
        .cfg_ready_i    (cfg_ready_i),
        .evt_rx_eot_i   (evt_rx_eot_i),
        .evt_tx_eot_i   (evt_tx_eot_i),
        .busy_o         (busy_o),
        .owner_o        (owner_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [NB-1:0] oh(input int i);
        logic [NB-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic void set_desc(input int i, input logic rd, input logic [L2_AW-1:0] l2,
                                     input logic [31:0] ext, input logic [SIZE_W-1:0] size);
        d_rd[i]   = rd;
        d_l2[i]   = l2;
        d_ext[i]  = ext;
        d_size[i] = size;
    endfunction

    function automatic void push_cfg(input int s);
        q_cfg.push_back('{addr: OFF_L2,   data: 32'(d_l2[s])});
        q_cfg.push_back('{addr: OFF_SIZE, data: 32'(d_size[s])});
        q_cfg.push_back('{addr: OFF_EXT,  data: d_ext[s]});
        q_cfg.push_back('{addr: OFF_CMD,  data: {30'b0, d_rd[s], 1'b1}});
    endfunction

    // Drive a valid vector at a falling edge, check the predicted grant, and
    // move to the next falling edge (the acceptance edge has passed by then).
    task automatic issue(input logic [NB-1:0] vld, input bit hold, output int sel);
        int            s;
        int            c;
        logic [NB-1:0] exp_rdy;
        req_valid_i = vld;
        #1;
        s = 0;
        for (int k = NB - 1; k >= 0; k--) begin
            c = (m_ptr + k) % NB;
            if (vld[c]) s = c;
        end
        exp_rdy = oh(s);
        checks++;
        if (req_ready_o !== exp_rdy) begin
            errors++;
            $display("FAIL grant: req_ready_o=%b expected %b", req_ready_o, exp_rdy);
        end
        if (d_size[s] != '0) push_cfg(s);
        m_ptr = (s + 1) % NB;
        sel   = s;
        @(negedge sys_clk_i);
        if (!hold) req_valid_i = '0;
        checks++;
        if (owner_o !== OW'(s) || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL owner: owner_o=%0d busy_o=%b expected %0d/1", owner_o, busy_o, s);
        end
    endtask

    // Pop the scoreboard as the cfg port delivers writes; optional stall
    // cycles with cfg_ready_i low on every write.
    task automatic drain_cfg(input int stall);
        cfg_wr_t exp;
        int      budget;
        budget = 50;
        checks++;
        if (cfg_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL cfg_start: cfg_valid_o=%b expected 1", cfg_valid_o);
        end
        while (q_cfg.size() != 0 && budget > 0) begin
            if (cfg_valid_o === 1'b1) begin
                exp = q_cfg.pop_front();
                checks++;
                if (cfg_addr_o !== exp.addr || cfg_data_o !== exp.data || cfg_rwn_o !== 1'b0) begin
                    errors++;
                    $display("FAIL cfg_write: addr=%h data=%h rwn=%b expected addr=%h data=%h rwn=0",
                             cfg_addr_o, cfg_data_o, cfg_rwn_o, exp.addr, exp.data);
                end
                for (int s = 0; s < stall; s++) begin
                    cfg_ready_i = 1'b0;
                    @(negedge sys_clk_i);
                    checks++;
                    if (cfg_valid_o !== 1'b1 || cfg_addr_o !== exp.addr || cfg_data_o !== exp.data) begin
                        errors++;
                        $display("FAIL cfg_stall: valid=%b addr=%h data=%h expected 1 %h %h",
                                 cfg_valid_o, cfg_addr_o, cfg_data_o, exp.addr, exp.data);
                    end
                end
                cfg_ready_i = 1'b1;
                @(negedge sys_clk_i);
                if (q_cfg.size() != 0) begin
                    checks++;
                    if (cfg_valid_o !== 1'b1) begin
                        errors++;
                        $display("FAIL cfg_gap: cfg_valid_o=%b expected 1 between writes", cfg_valid_o);
                    end
                end
            end else begin
                budget--;
                @(negedge sys_clk_i);
            end
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL cfg_budget: %0d writes never appeared", q_cfg.size());
            q_cfg.delete();
        end
    endtask

    // Pulse the end-of-transfer inputs for one cycle and check the outcome.
    task automatic end_evt(input bit rx, input bit tx, input bit exp_done, input int who);
        logic [NB-1:0] exp;
        evt_rx_eot_i = rx;
        evt_tx_eot_i = tx;
        @(negedge sys_clk_i);
        evt_rx_eot_i = 1'b0;
        evt_tx_eot_i = 1'b0;
        exp = exp_done ? oh(who) : '0;
        checks++;
        if (done_o !== exp || err_o !== '0 || busy_o !== !exp_done) begin
            errors++;
            $display("FAIL completion: done=%b err=%b busy=%b expected done=%b err=0 busy=%b",
                     done_o, err_o, busy_o, exp, !exp_done);
        end
    endtask

    task automatic test_reset();
        rstn_i       = 1'b0;
        req_valid_i  = '0;
        cfg_ready_i  = 1'b1;
        evt_rx_eot_i = 1'b0;
        evt_tx_eot_i = 1'b0;
        timeout_i    = '0;
        for (int i = 0; i < NB; i++) set_desc(i, 1'b0, '0, '0, '0);
        repeat (2) @(negedge sys_clk_i);
        checks++;
        if ({req_ready_o, done_o, err_o, cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o, busy_o, owner_o} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs not all zero (busy=%b cfg_valid=%b)", busy_o, cfg_valid_o);
        end
        rstn_i = 1'b1;
        @(negedge sys_clk_i);
        checks++;
        if ({req_ready_o, done_o, err_o, cfg_valid_o, cfg_addr_o, cfg_data_o, busy_o, owner_o} !== '0) begin
            errors++;
            $display("FAIL reset_release: outputs not all zero (busy=%b cfg_valid=%b)", busy_o, cfg_valid_o);
        end
    endtask

    task automatic test_single_write();
        int s;
        set_desc(0, 1'b0, 19'h100, 32'h2000, 20'd64);
        // Stray event in IDLE must be dropped.
        evt_tx_eot_i = 1'b1;
        @(negedge sys_clk_i);
        evt_tx_eot_i = 1'b0;
        @(negedge sys_clk_i);
        checks++;
        if (done_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_evt: done=%b busy=%b expected 0/0", done_o, busy_o);
        end
        issue(2'b01, 1'b0, s);
        drain_cfg(0);
        repeat (2) @(negedge sys_clk_i);
        checks++;
        if (done_o !== '0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle: done=%b busy=%b expected 0/1", done_o, busy_o);
        end
        end_evt(1'b0, 1'b1, 1'b1, 0);
        @(negedge sys_clk_i);
        checks++;
        if (done_o !== '0) begin
            errors++;
            $display("FAIL done_width: done=%b expected 0 one cycle later", done_o);
        end
    endtask

    task automatic test_read_backpressure();
        int s;
        set_desc(1, 1'b1, 19'h7FFFF, 32'hDEADBEEF, 20'h12345);
        issue(2'b10, 1'b0, s);
        drain_cfg(3);
        end_evt(1'b0, 1'b1, 1'b0, 1);
        end_evt(1'b1, 1'b1, 1'b1, 1);
    endtask

    task automatic test_round_robin();
        int s;
        int exp_seq [4] = '{0, 1, 0, 1};
        set_desc(0, 1'b0, 19'h40, 32'h1000, 20'd16);
        set_desc(1, 1'b0, 19'h80, 32'h3000, 20'd32);
        for (int k = 0; k < 4; k++) begin
            issue(2'b11, 1'b1, s);
            checks++;
            if (s != exp_seq[k]) begin
                errors++;
                $display("FAIL rr_order: grant %0d went to %0d expected %0d", k, s, exp_seq[k]);
            end
            drain_cfg(0);
            end_evt(1'b0, 1'b1, 1'b1, s);
        end
        req_valid_i = '0;
    endtask

    task automatic test_rerequest();
        int s;
        set_desc(1, 1'b0, 19'h11, 32'h2222, 20'd4);
        for (int k = 0; k < 2; k++) begin
            issue(2'b10, 1'b0, s);
            checks++;
            if (s != 1) begin
                errors++;
                $display("FAIL rereq: grant went to %0d expected 1", s);
            end
            drain_cfg(0);
            end_evt(1'b0, 1'b1, 1'b1, 1);
        end
    endtask

    task automatic test_size_zero();
        int s;
        set_desc(1, 1'b0, 19'h10, 32'h10, 20'd0);
        issue(2'b10, 1'b0, s);
        checks++;
        if (err_o !== 2'b10 || done_o !== '0 || cfg_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL size0_err: err=%b done=%b cfg_valid=%b expected 10/00/0", err_o, done_o, cfg_valid_o);
        end
        @(negedge sys_clk_i);
        checks++;
        if (err_o !== '0 || busy_o !== 1'b0 || cfg_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL size0_after: err=%b busy=%b cfg_valid=%b expected 00/0/0", err_o, busy_o, cfg_valid_o);
        end
        set_desc(0, 1'b0, 19'h55, 32'h6600, 20'd8);
        issue(2'b11, 1'b0, s);
        checks++;
        if (s != 0) begin
            errors++;
            $display("FAIL size0_ptr: grant went to %0d expected 0", s);
        end
        drain_cfg(0);
        end_evt(1'b0, 1'b1, 1'b1, 0);
    endtask

    task automatic test_watchdog();
        int s;
        timeout_i = 16'd10;
        set_desc(0, 1'b0, 19'h200, 32'h4000, 20'd8);
        issue(2'b01, 1'b0, s);
        drain_cfg(0);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (err_o !== '0 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL wdog_early: cycle %0d err=%b busy=%b expected 00/1", k, err_o, busy_o);
            end
            @(negedge sys_clk_i);
        end
        checks++;
        if (err_o !== 2'b01 || done_o !== '0) begin
            errors++;
            $display("FAIL wdog_fire: err=%b done=%b expected 01/00", err_o, done_o);
        end
        @(negedge sys_clk_i);
        checks++;
        if (err_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL wdog_after: err=%b busy=%b expected 00/0", err_o, busy_o);
        end

        // Disabled watchdog: a read waits far beyond any small limit.
        timeout_i = '0;
        set_desc(1, 1'b1, 19'h300, 32'h8000, 20'd12);
        issue(2'b10, 1'b0, s);
        drain_cfg(0);
        for (int k = 0; k < 40; k++) begin
            @(negedge sys_clk_i);
            checks++;
            if (err_o !== '0 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL wdog_off: cycle %0d err=%b busy=%b expected 00/1", k, err_o, busy_o);
            end
        end
        end_evt(1'b1, 1'b0, 1'b1, 1);

        // Event landing on the timeout cycle: done wins.
        timeout_i = 16'd10;
        issue(2'b01, 1'b0, s);
        drain_cfg(0);
        repeat (9) @(negedge sys_clk_i);
        end_evt(1'b0, 1'b1, 1'b1, 0);
        @(negedge sys_clk_i);
        checks++;
        if (err_o !== '0) begin
            errors++;
            $display("FAIL wdog_tie: err=%b expected 00 after done", err_o);
        end
        timeout_i = '0;
    endtask

    task automatic test_reset_mid();
        int s;
        int budget;
        set_desc(1, 1'b0, 19'h33, 32'h5555, 20'd100);
        issue(2'b10, 1'b0, s);
        budget = 10;
        while (!(cfg_valid_o === 1'b1 && cfg_addr_o === OFF_EXT) && budget > 0) begin
            @(negedge sys_clk_i);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL rst_mid_reach: OFF_EXT write not seen, addr=%h", cfg_addr_o);
        end
        #1 rstn_i = 1'b0;
        #1;
        checks++;
        if ({req_ready_o, done_o, err_o, cfg_valid_o, cfg_addr_o, cfg_data_o, busy_o, owner_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid: outputs not zero, cfg_valid=%b busy=%b owner=%0d", cfg_valid_o, busy_o, owner_o);
        end
        q_cfg.delete();
        m_ptr = 0;
        @(negedge sys_clk_i);
        rstn_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk_i);
            checks++;
            if (done_o !== '0 || err_o !== '0 || busy_o !== 1'b0 || cfg_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_quiet: done=%b err=%b busy=%b cfg_valid=%b expected all 0",
                         done_o, err_o, busy_o, cfg_valid_o);
            end
        end
        issue(2'b10, 1'b0, s);
        drain_cfg(0);
        end_evt(1'b0, 1'b1, 1'b1, 1);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_backpressure();
        test_round_robin();
        test_rerequest();
        test_size_zero();
        test_watchdog();
        test_reset_mid();
        repeat (2) @(negedge sys_clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hyper_xfer_sequencer.md
Name: hyper_xfer_sequencer

Overview:
- Schedules HyperBus transfers from NB_REQ requesters onto the single uDMA HyperBus channel.
- Selects one requester with round-robin arbitration. Programs the channel through a fixed 4-write burst on the uDMA cfg bus, then waits for the matching read or write end-of-transfer event.
- Returns done or error status to the requester that owns the transfer.
- Sits between cluster/SoC masters and the hyper macro cfg port. Direction is taken from the issued descriptor rather than inferred from channel events.

Parameters:
- NB_REQ, 2, number of requesters (2..8).
- L2_AW, 19, L2 address width (L2_AWIDTH_NOAL).
- SIZE_W, 20, transfer size width (TRANS_SIZE).
- OFF_L2, 6'h00, cfg offset of the L2 start-address register.
- OFF_SIZE, 6'h04, cfg offset of the size register.
- OFF_EXT, 6'h08, cfg offset of the external (HyperRAM) address register.
- OFF_CMD, 6'h0C, cfg offset of the command register: bit0 = start, bit1 = read.
- TIMEOUT_W, 16, width of the end-of-transfer watchdog counter.

Ports:
- sys_clk_i, in, 1, clock.
- rstn_i, in, 1, asynchronous active-low reset.
- req_valid_i, in, NB_REQ, per-requester descriptor valid.
- req_ready_o, out, NB_REQ, descriptor accepted (one-hot pulse).
- req_rd_i, in, NB_REQ, 1 = HyperBus read into L2, 0 = write from L2.
- req_l2_addr_i, in, NB_REQ*L2_AW, packed L2 addresses.
- req_ext_addr_i, in, NB_REQ*32, packed external addresses.
- req_size_i, in, NB_REQ*SIZE_W, packed byte counts.
- done_o, out, NB_REQ, one-cycle completion pulse to the owning requester.
- err_o, out, NB_REQ, one-cycle error pulse (size 0 or timeout).
- timeout_i, in, TIMEOUT_W, watchdog limit in cycles; 0 disables the watchdog.
- cfg_valid_o, out, 1, cfg write valid.
- cfg_rwn_o, out, 1, always 0 (write).
- cfg_addr_o, out, 6, register offset.
- cfg_data_o, out, 32, write data (zero-extended).
- cfg_ready_i, in, 1, cfg accept.
- evt_rx_eot_i, in, 1, read end-of-transfer pulse.
- evt_tx_eot_i, in, 1, write end-of-transfer pulse.
- busy_o, out, 1, a transfer is owned.
- owner_o, out, $clog2(NB_REQ), index of the current owner.

Behaviour:
- Reset: all outputs 0. State = IDLE. Round-robin pointer = 0. Watchdog counter = 0.
- States: IDLE -> CFG -> WAIT_EOT -> IDLE; IDLE -> FAIL -> IDLE.
- IDLE arbitration:
  - If any req_valid_i is set, select the first set index at or after the pointer, wrapping modulo NB_REQ.
  - In the same cycle: pulse req_ready_o[sel]; latch rd, l2, ext and size into internal registers; set owner_o = sel; move the pointer to sel+1 (wrapping).
  - If the latched size is 0, go to FAIL. Otherwise go to CFG with write index 0.
- CFG:
  - Issue writes in order OFF_L2, OFF_SIZE, OFF_EXT, OFF_CMD. CMD data = {30'b0, rd, 1'b1}.
  - cfg_valid_o stays high and addr/data stay stable until cfg_ready_i is sampled high. Then advance the write index.
  - At most one write completes per cycle. There is no idle cycle between writes.
  - After the CMD handshake, go to WAIT_EOT and clear the watchdog.
- WAIT_EOT:
  - Read transfers complete on evt_rx_eot_i; write transfers complete on evt_tx_eot_i.
  - The non-matching event is ignored. This holds even when it arrives in the same cycle as the matching event, in which case the matching event still completes the transfer.
  - On completion: done_o[owner] pulses in the next cycle and the state returns to IDLE.
  - Watchdog: increments each cycle in WAIT_EOT. If timeout_i != 0 and the counter equals timeout_i, go to FAIL.
  - An event arriving in the same cycle as the timeout wins: done, not error.
- FAIL: err_o[owner] pulses for one cycle, then the state returns to IDLE.
- busy_o is 1 in every state except IDLE.
- Minimum latency from acceptance to CMD write: 4 cycles with cfg_ready_i held at 1.
- Arbitration occurs only in IDLE. Requests arriving while busy wait; req_valid_i must be held until req_ready_o.
- Reset mid-transfer: the block returns to IDLE immediately. No done or err pulse is produced. Any in-flight cfg write is abandoned (cfg_valid_o drops asynchronously).
- EOT events seen in IDLE or CFG are dropped.

Test Plan:
- Single write: req0 with rd=0, l2=0x100, ext=0x2000, size=64, cfg_ready_i=1.
  - Required: cfg writes (00,0x100), (04,64), (08,0x2000), (0C,0x1) on consecutive cycles.
  - Then evt_tx_eot_i -> done_o[0] pulse, busy_o=0.
- Read with backpressure: cfg_ready_i low 3 cycles on each write.
  - Required: addr/data stable while stalled; CMD data = 0x3.
  - evt_tx_eot_i is ignored; evt_rx_eot_i -> done_o.
- Round-robin: NB_REQ=2, both requesters valid continuously.
  - Required: grants alternate 0,1,0,1 over 4 transfers.
  - When a single requester re-requests, it is granted in the next IDLE.
- Size 0 from req1 -> no cfg writes; err_o[1] pulses; pointer advances to 0.
- Watchdog: timeout_i=10 and no event.
  - Required: err_o pulses after 10 WAIT_EOT cycles.
  - With timeout_i=0: waits indefinitely. An event in the same cycle as the timeout -> done_o, not err_o.
- Reset asserted during the CFG write to OFF_EXT -> all outputs 0 immediately; the next request restarts at OFF_L2.
